// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO stream reader.
// Occupancy states double as the buffer level.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    function automatic logic [1:0] occ_level(occ_t s);
        return s;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream with burst framing.
// master drives the word, slave returns ready.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 32
) ();

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer: out drives the stream, skid absorbs a stall.
// i_mark tags the newest word that stays buffered after this cycle.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_pop,
    input  logic              i_mark,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [1:0]        o_level
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    occ_t  r_state;
    occ_t  w_next;
    word_t r_out;
    word_t r_skid;
    word_t w_in;

    assign w_in = '{data: i_data, last: i_last};

    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            EMPTY: begin
                if (i_load) w_next = ONE;
            end
            ONE: begin
                if (i_load && !i_pop)      w_next = TWO;
                else if (!i_load && i_pop) w_next = EMPTY;
            end
            TWO: begin
                if (i_pop) w_next = ONE;
            end
            default: w_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (i_load) r_out <= w_in;
                end
                ONE: begin
                    if (i_load && i_pop)  r_out <= w_in;
                    else if (i_load)      r_skid <= w_in;
                    else if (!i_pop && i_mark)
                        r_out.last <= 1'b1;
                end
                TWO: begin
                    // skid slides forward, keeping any flush tag
                    if (i_pop) begin
                        r_out.data <= r_skid.data;
                        r_out.last <= r_skid.last | i_mark;
                    end else if (i_mark) begin
                        r_skid.last <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_state != EMPTY);
    assign o_data  = r_out.data;
    assign o_last  = r_out.last;
    assign o_level = occ_level(r_state);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains an FWFT FIFO onto a framed valid/ready stream.
// Pops depend only on f_empty and registered state, never on m_ready.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int BEAT_W    = $clog2(BURST_LEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_empty,
    input  logic [DATA_W-1:0]    f_r_data,
    output logic                 f_r_req,
    fifo_stream_reader_if.master m,
    input  logic                 flush,
    output logic [1:0]           level,
    output logic [15:0]          burst_cnt
);

    localparam logic [BEAT_W-1:0] LP_BEAT_MAX =
        BEAT_W'(BURST_LEN - 1);

    logic [BEAT_W-1:0] r_beat;
    logic              r_flush_pend;
    logic [15:0]       r_burst;
    logic              w_load;
    logic              w_pop;
    logic              w_ld_last;
    logic              w_mark;
    logic              w_pend;

    assign f_r_req = ~rst & ~f_empty & (level != 2'd2);
    assign w_load  = f_r_req;
    assign w_pop   = m.m_valid & m.m_ready;

    assign w_ld_last = (r_beat == LP_BEAT_MAX) | flush | r_flush_pend;

    // A word leaving this cycle can no longer be tagged, so only a
    // word that remains buffered is eligible for the flush mark.
    assign w_mark = flush & ~w_load &
                    ((level == 2'd2) | ((level == 2'd1) & ~w_pop));
    assign w_pend = flush & ~w_load & ~w_mark & (r_beat != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_burst      <= '0;
        end else begin
            if (w_load) begin
                if (w_ld_last) begin
                    r_beat       <= '0;
                    r_flush_pend <= 1'b0;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end else if (w_mark) begin
                r_beat <= '0;
            end else if (w_pend) begin
                r_flush_pend <= 1'b1;
            end
            if (w_pop && m.m_last) r_burst <= r_burst + 16'd1;
        end
    end

    stream_skid_buf #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (f_r_data),
        .i_last (w_ld_last),
        .i_pop  (w_pop),
        .i_mark (w_mark),
        .o_valid(m.m_valid),
        .o_data (m.m_data),
        .o_last (m.m_last),
        .o_level(level)
    );

    assign burst_cnt = r_burst;

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain engine for the single-clock FWFT FIFO: pops words from the FIFO's read port and presents them on a valid/ready stream with burst framing (`m_last` every `BURST_LEN` words or on `flush`). It sits between a FIFO instance and any stream consumer. Backpressure is absorbed by a two-entry output buffer, so `f_r_req` never depends combinationally on `m_ready`.

## Interface
- `DATA_W`, 32, data width; must match the FIFO.
- `BURST_LEN`, 16, words per burst; ≥1.
- `BEAT_W`, `$clog2(BURST_LEN)+1`, beat counter width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `f_empty`  in  1  FIFO empty flag.
- `f_r_data`  in  DATA_W  FIFO head word, valid while `~f_empty` (FWFT).
- `f_r_req`  out  1  pop request to the FIFO.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  DATA_W  stream word.
- `m_last`  out  1  last word of burst.
- `m_ready`  in  1  consumer accepts the word.
- `flush`  in  1  one-cycle pulse: close the current burst early.
- `level`  out  2  buffer occupancy, 0..2.
- `burst_cnt`  out  16  completed bursts (`m_last` handshakes), wraps.

## Operation
- Buffer: two entries, `out` (drives `m_*`) and `skid`, each holding data plus a last tag. `level` is a registered 0..2 count.
- `f_r_req = ~f_empty & (level < 2)`. It never asserts while `f_empty`, so the FIFO fail condition is never triggered. It is combinational from `f_empty` and registers only.
- Load: when `f_r_req` is high, `f_r_data` is captured at that edge. The destination is `out` if `out` is empty or being drained this cycle and `skid` is empty; otherwise it is `skid`.
- Handshake: a word transfers when `m_valid & m_ready`. On transfer, `skid` moves to `out` if occupied. `m_data` and `m_last` stay stable while `m_valid & ~m_ready`.
- Beat counter: counts loaded words 0..BURST_LEN-1. The word loaded at count BURST_LEN-1 gets last=1 and the counter returns to 0.
- Flush, resolved in priority order:
  - If a word loads in the same cycle, that word gets last=1 and the counter clears.
  - Otherwise, if `level>0`, the newest buffered word gets last=1 and the counter clears.
  - Otherwise, if the counter is nonzero, `flush_pend` is set and the next loaded word gets last=1.
  - Otherwise (counter 0, buffer empty), flush is ignored.
- A flush arriving while `flush_pend` is already set has no additional effect.
- `burst_cnt` increments on each handshake with `m_last=1`.
- No state machine beyond the occupancy states EMPTY(0), ONE(1), TWO(2):
  - EMPTY → ONE on load.
  - ONE → TWO on load without transfer.
  - ONE → EMPTY on transfer without load.
  - ONE → ONE on load with transfer.
  - TWO → ONE on transfer. No load is possible in TWO.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `m_last=0`, `level=0`, `burst_cnt=0`, beat counter 0, `flush_pend=0`. `f_r_req=0` during reset.
- Latency: a word at the FIFO head with an empty buffer appears on `m_data` one cycle after `f_r_req` is high.
- Throughput: 1 word/cycle sustained while `m_ready=1` and the FIFO is non-empty.
- With `m_ready=0`, at most 2 words are popped, then `f_r_req` drops until a transfer.
- Reset mid-operation drops buffered words; words not yet popped remain in the FIFO.

## Structure
- Package `fifo_stream_reader_pkg`: `occ_t` (2-bit occupancy enum EMPTY/ONE/TWO) and a `word_t` struct {data, last}, parameterized via the module's `DATA_W`. If the struct cannot take `DATA_W` from a package, keep it local.
- One sub-module: `stream_skid_buf`, the two-entry buffer (load/pop/level). Framing, flush and counters stay in the top.

## Test plan
- FIFO preloaded with 0x00..0x1F, `BURST_LEN=16`, `m_ready=1` → 32 consecutive beats, `m_last` on 0x0F and 0x1F, `burst_cnt=2`, first word one cycle after `f_r_req`.
- `m_ready=0` with 5 words in the FIFO → exactly 2 pops, `level=2`, `f_r_req=0`. Release `m_ready` → order preserved, all 5 delivered.
- 3 words drained, then `flush` with buffer empty → `flush_pend=1`. Next word 0xAA arrives → emitted with `m_last=1`, beat counter restarts at 0.
- `flush` in the same cycle as a load of 0x55 → 0x55 carries `m_last=1`. The following burst is a full 16 words.
- Random `m_ready` (50%) over 1000 words → no loss, duplication or reorder, `f_r_req` never high with `f_empty`, `m_data` stable under stall.
- `rst` asserted with `level=2` → next cycle `m_valid=0`, `level=0`, `burst_cnt=0`. FIFO contents intact.
